// File: rtl/sparse_mac_pkg.sv
// Shared types and helpers for the sparse row MAC: FSM state, drop counter
// width and a width-generic saturating add.
package sparse_mac_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DROP_W = 16;
  localparam int SAT_W  = 64;

  // Operands arrive already extended to SAT_W, so the raw sum cannot overflow
  // for any accumulator narrower than SAT_W-1 bits; only the clamp matters.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      acc_w,
    input bit                      sgn
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s = a + b;
    if (sgn) begin
      hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (acc_w - 1));
    end else begin
      hi = (64'sd1 <<< acc_w) - 64'sd1;
      lo = '0;
    end
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/sparse_mac_row_sat_acc_add.sv
// Combinational saturating adder: accumulator plus full-width product,
// clamped to the accumulator range, signed or unsigned.
module sat_acc_add
  import sparse_mac_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int PROD_W = 16,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic signed [SAT_W-1:0] acc_x;
  logic signed [SAT_W-1:0] prod_x;

  generate
    if (SIGNED != 0) begin : g_sext
      assign acc_x  = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
      assign prod_x = {{(SAT_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    end else begin : g_zext
      assign acc_x  = {{(SAT_W-ACC_W){1'b0}}, acc_i};
      assign prod_x = {{(SAT_W-PROD_W){1'b0}}, prod_i};
    end
  endgenerate

  assign sum_o = ACC_W'(sat_add(acc_x, prod_x, ACC_W, SIGNED != 0));

endmodule

// File: rtl/sparse_mac_row.sv
// Sparse MAC row: accumulates in*weight into acc[index_in-index_w] through a
// two-stage pipeline, then drains the whole row as a handshaked stream.
module sparse_mac_row
  import sparse_mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 8,
  parameter int ROW_LEN = 32,
  parameter int ACC_W   = 20,
  parameter int SIGNED  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] weight,
  input  logic [IDX_W-1:0]  index_in,
  input  logic [IDX_W-1:0]  index_w,
  input  logic              row_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  output logic [IDX_W-1:0]  index_o,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int                PROD_W    = 2 * DATA_W;
  localparam int                AW        = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IDX_W:0]    ROW_LEN_L = (IDX_W+1)'(ROW_LEN);
  localparam logic [AW-1:0]     K_LAST    = AW'(ROW_LEN - 1);

  state_e              state_q;
  logic [AW-1:0]       k_q;
  logic [DROP_W-1:0]   drop_q;
  logic [ACC_W-1:0]    acc_q [ROW_LEN];

  logic                vld_p1_q, inr_p1_q, vld_p2_q;
  logic [PROD_W-1:0]   prod_p1_q, prod_p2_q;
  logic [AW-1:0]       pos_p1_q, pos_p2_q;

  logic                accept;
  logic                drain_fire;
  logic [IDX_W:0]      pos_w;
  logic                in_range_w;
  logic [PROD_W-1:0]   prod_w;
  logic [ACC_W-1:0]    sum_w;

  assign in_ready   = (state_q == ST_ACCUM);
  assign busy       = (state_q != ST_ACCUM);
  assign out_valid  = (state_q == ST_DRAIN);
  assign accept     = in_valid && in_ready;
  assign drain_fire = out_valid && out_ready;
  assign drop_cnt   = drop_q;
  assign out        = out_valid ? acc_q[k_q] : '0;
  assign index_o    = out_valid ? IDX_W'(k_q) : '0;

  assign pos_w      = {1'b0, index_in} - {1'b0, index_w};
  assign in_range_w = !pos_w[IDX_W] && (pos_w < ROW_LEN_L);

  generate
    if (SIGNED != 0) begin : g_smul
      logic signed [PROD_W-1:0] a_s, b_s;
      assign a_s    = {{DATA_W{in[DATA_W-1]}}, in};
      assign b_s    = {{DATA_W{weight[DATA_W-1]}}, weight};
      assign prod_w = a_s * b_s;
    end else begin : g_umul
      assign prod_w = {{DATA_W{1'b0}}, in} * {{DATA_W{1'b0}}, weight};
    end
  endgenerate

  // ---- stage 1: product, position and range flag ----
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p1_q <= prod_w;
      pos_p1_q  <= pos_w[AW-1:0];
      inr_p1_q  <= in_range_w;
    end
  end

  // ---- stage 2: RMW of acc[pos]; a one-cycle RMW means a hit on the same
  // position next cycle already reads the freshly written value ----
  always_ff @(posedge clk) begin
    prod_p2_q <= prod_p1_q;
    pos_p2_q  <= pos_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q && inr_p1_q;
    end
  end

  sat_acc_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W),
    .SIGNED (SIGNED)
  ) u_add (
    .acc_i  (acc_q[pos_p2_q]),
    .prod_i (prod_p2_q),
    .sum_o  (sum_w)
  );

  // Stage-2 writes and drain clears never overlap: the pipe is empty in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROW_LEN; i++) acc_q[i] <= '0;
    end else if (vld_p2_q) begin
      acc_q[pos_p2_q] <= sum_w;
    end else if (drain_fire) begin
      acc_q[k_q] <= '0;
    end
  end

  // ---- control: row FSM, drain pointer, drop counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      k_q     <= '0;
      drop_q  <= '0;
    end else begin
      if (accept && !in_range_w && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      case (state_q)
        ST_ACCUM: if (row_done) state_q <= ST_FLUSH;
        // Stage 2 retires on the same edge that leaves FLUSH.
        ST_FLUSH: begin
          k_q <= '0;
          if (!vld_p1_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_ready) begin
            k_q <= k_q + 1'b1;
            if (k_q == K_LAST) begin
              state_q <= ST_ACCUM;
              drop_q  <= '0;
            end
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_mac_row.sv
// Scoreboard bench for sparse_mac_row: directed rows, expected drains queued
// at row end and checked by an independent output monitor.
module tb_sparse_mac_row;

  localparam int ROW_LEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  din = '0;
  logic [7:0]  weight = '0;
  logic [7:0]  index_in = '0;
  logic [7:0]  index_w = '0;
  logic        row_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] dout;
  logic [7:0]  index_o;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  sparse_mac_row #(
    .DATA_W (8), .IDX_W (8), .ROW_LEN (ROW_LEN), .ACC_W (20), .SIGNED (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .weight    (weight),
    .index_in  (index_in),
    .index_w   (index_w),
    .row_done  (row_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .index_o   (index_o),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  typedef struct { longint val; longint idx; } exp_t;
  exp_t   exp_q[$];
  longint exp_row[ROW_LEN];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Output monitor: pops on each handshake, checks held values while stalled.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        if (out_ready) check("unexpected_out_beat", longint'(index_o), -1);
      end else if (out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check("drain_value", longint'(dout), e.val);
        check("drain_index", longint'(index_o), e.idx);
      end else begin
        check("stall_value", longint'(dout), exp_q[0].val);
        check("stall_index", longint'(index_o), exp_q[0].idx);
      end
    end
  end

  task automatic beat(input int a, input int w, input int ii, input int iw, input bit done);
    in_valid = 1'b1;
    din      = 8'(a);
    weight   = 8'(w);
    index_in = 8'(ii);
    index_w  = 8'(iw);
    row_done = done;
    @(posedge clk); #1;
    in_valid = 1'b0;
    row_done = 1'b0;
  endtask

  task automatic clear_row();
    for (int k = 0; k < ROW_LEN; k++) exp_row[k] = 0;
  endtask

  task automatic push_row();
    for (int k = 0; k < ROW_LEN; k++) exp_q.push_back('{exp_row[k], longint'(k)});
  endtask

  task automatic do_row_done();
    push_row();
    row_done = 1'b1;
    @(posedge clk); #1;
    row_done = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, busy=%0d", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", dout, 0);
    check("rst_index_o", index_o, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    out_ready = 1'b1;

    // Basic product 59*3 at position 2
    clear_row(); exp_row[2] = 177;
    beat(59, 3, 2, 0, 1'b0);
    do_row_done();
    check("flush_in_ready", in_ready, 0);
    check("flush_busy", busy, 1);
    wait_drained(100);

    // Out-of-range: pos -1 and pos 40
    clear_row();
    beat(5, 5, 2, 3, 1'b0);
    beat(5, 5, 40, 0, 1'b0);
    check("drop_cnt_2", drop_cnt, 2);
    do_row_done();
    wait_drained(100);
    check("drop_cnt_cleared", drop_cnt, 0);

    // Forwarding: four back-to-back hits on pos 21, last one with row_done
    clear_row(); exp_row[21] = 708;
    push_row();
    beat(59, 3, 25, 4, 1'b0);
    beat(59, 3, 25, 4, 1'b0);
    beat(59, 3, 25, 4, 1'b0);
    beat(59, 3, 25, 4, 1'b1);
    wait_drained(100);

    // Saturation: 17*65025 exceeds 2^20-1
    clear_row(); exp_row[0] = 1048575;
    for (int i = 0; i < 17; i++) beat(255, 255, 0, 0, 1'b0);
    do_row_done();
    wait_drained(100);
    clear_row(); exp_row[0] = 65025;
    beat(255, 255, 0, 0, 1'b0);
    do_row_done();
    wait_drained(100);

    // Drain backpressure with in_valid asserted throughout the drain
    clear_row();
    for (int k = 0; k < ROW_LEN; k++) begin
      exp_row[k] = k + 1;
      beat(k + 1, 1, k, 0, 1'b0);
    end
    do_row_done();
    begin
      int c = 0;
      out_ready = 1'b0;
      while (busy && c < 400) begin
        in_valid = 1'b1; din = 8'd9; weight = 8'd9; index_in = 8'd3; index_w = 8'd0;
        check("bp_in_ready_low", in_ready, 0);
        out_ready = ~out_ready;
        @(posedge clk); #1;
        c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_row_finished", busy, 0);
      check("bp_queue_empty", exp_q.size(), 0);
      exp_q.delete();
    end
    clear_row();
    do_row_done();
    wait_drained(100);

    // Reset after 5 accepted drain entries
    clear_row(); exp_row[7] = 100;
    beat(10, 10, 7, 0, 1'b0);
    out_ready = 1'b0;
    do_row_done();
    begin
      int c = 0;
      while (!out_valid && c < 20) begin
        @(posedge clk); #1;
        c++;
      end
      check("rm_drain_started", out_valid, 1);
    end
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rm_five_popped", exp_q.size(), ROW_LEN - 5);
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rm_out_valid", out_valid, 0);
    check("rm_in_ready", in_ready, 1);
    check("rm_busy", busy, 0);
    check("rm_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_row(); exp_row[9] = 6;
    beat(2, 3, 9, 0, 1'b0);
    do_row_done();
    wait_drained(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
